read_data_channel: RTL and testbench

Read-return datapath of the DDR controller's AXI slave. It takes right-justified beats from the memory read pipeline, places each beat on the correct AXI byte lanes for the burst's size and start address, and buffers the beats in a small FIFO. It drives the AXI R channel (RVALID/RREADY/RDATA/RLAST/RRESP) towards the host. It pairs with the write-data register on the W channel.

---
 rtl/ddr_axi_pkg.sv | 43 ++++
 rtl/read_data_channel_if.sv | 21 ++
 rtl/rdata_fifo.sv | 57 +++++
 rtl/read_data_channel.sv | 146 ++++++++++++++
 tb/tb_read_data_channel.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared types for the DDR controller AXI read-return path.
// Response codes, AXI size codes, R-path FSM states and FIFO entry.
package ddr_axi_pkg;

  localparam int AXI_DATA_W = 64;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } rdc_state_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
    resp_t                 resp;
  } rdc_entry_t;

  // Right-justified active byte lanes for an AXI size; illegal sizes
  // select no bytes so the beat data collapses to zero.
  function automatic logic [7:0] byte_mask(input logic [2:0] size);
    logic [7:0] m;
    m = 8'h00;
    unique case (size)
      SIZE_1B: m = 8'h01;
      SIZE_2B: m = 8'h03;
      SIZE_4B: m = 8'h0f;
      SIZE_8B: m = 8'hff;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/read_data_channel_if.sv
// AXI R channel bundle between the read-return datapath and host.
// master: RVALID/RDATA/RLAST/RRESP out, RREADY in; slave: mirror.
interface read_data_channel_if #(
  parameter int DATA_W = 64
);
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic [1:0]        RRESP;

  modport master (
    output RVALID, RDATA, RLAST, RRESP,
    input  RREADY
  );

  modport slave (
    input  RVALID, RDATA, RLAST, RRESP,
    output RREADY
  );
endinterface

// File: rtl/rdata_fifo.sv
// Synchronous FIFO of R beats; head is read straight from flops.
// Ports: push/din, pop/dout, full, empty, count (occupancy).
module rdata_fifo
  import ddr_axi_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rdc_entry_t
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop)
        rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_data_channel.sv
// Read-return datapath: lane-places memory beats, buffers, drives R.
// Optional READ_PARITY_CHECK_EN adds mem_parity[7:0] (even, per byte).
module read_data_channel
  import ddr_axi_pkg::*;
#(
  parameter int DATA_W     = AXI_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  start_len,
  input  logic [2:0]        start_size,
  input  logic [2:0]        start_addr_lsb,
  output logic              busy,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
`ifdef READ_PARITY_CHECK_EN
  input  logic [7:0]        mem_parity,
`endif
  read_data_channel_if.master r
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  rdc_state_t       state_q;
  rdc_state_t       state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [2:0]       size_q;
  logic [2:0]       lane_q;

  rdc_entry_t       din;
  rdc_entry_t       head;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             pop;
  logic             accept;
  logic             start_ok;
  logic             legal_q;
  logic             par_err;
  logic [7:0]       bmask;
  logic [3:0]       step;
  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] placed;

  assign pop       = r.RVALID && r.RREADY;
  assign mem_ready = (state_q == ACTIVE) && !full;
  assign accept    = mem_valid && mem_ready;
  assign busy      = (state_q == ACTIVE) || !empty;
  // The last entry leaving this cycle frees the block for a new burst.
  assign start_ok  = start && (state_q == IDLE) &&
                     (empty || (count == ONE && pop));

  assign legal_q = (size_q <= SIZE_8B);
  assign bmask   = byte_mask(size_q);
  assign step    = 4'd1 << size_q[1:0];

  always_comb begin
    masked = '0;
    for (int i = 0; i < 8; i++)
      if (bmask[i])
        masked[8*i +: 8] = mem_data[8*i +: 8];
    placed = masked << {lane_q, 3'b000};
  end

`ifdef READ_PARITY_CHECK_EN
  always_comb begin
    par_err = 1'b0;
    for (int i = 0; i < 8; i++)
      if (bmask[i] && ((^mem_data[8*i +: 8]) != mem_parity[i]))
        par_err = 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    din      = '0;
    din.data = placed;
    din.last = (cnt_q == len_q);
    din.resp = (!legal_q || par_err) ? SLVERR : OKAY;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ACTIVE;
      ACTIVE:  if (accept && cnt_q == len_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      size_q <= '0;
      lane_q <= '0;
    end else if (start_ok) begin
      len_q  <= start_len;
      cnt_q  <= '0;
      size_q <= start_size;
      // Align to the beat size; size 3 and illegal sizes start at lane 0.
      lane_q <= (start_size <= SIZE_8B)
                ? (start_addr_lsb & (3'b111 << start_size[1:0]))
                : 3'd0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
      if (legal_q)
        lane_q <= lane_q + step[2:0];
    end
  end

  rdata_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rdc_entry_t)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (accept),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign r.RVALID = !empty;
  assign r.RDATA  = head.data;
  assign r.RLAST  = head.last;
  assign r.RRESP  = head.resp;

endmodule

// File: tb/tb_read_data_channel.sv
// Directed bench for read_data_channel with an R-beat scoreboard.
// Expected beats are queued at drive time and checked on each R pop.
module tb_read_data_channel;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [1:0]  r;
  } exp_t;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [7:0]  start_len;
  logic [2:0]  start_size;
  logic [2:0]  start_addr_lsb;
  logic        busy;
  logic        mem_valid;
  logic [63:0] mem_data;
  logic        mem_ready;
`ifdef READ_PARITY_CHECK_EN
  logic [7:0]  mem_parity;
  always_comb
    for (int i = 0; i < 8; i++)
      mem_parity[i] = ^mem_data[8*i +: 8];
`endif

  read_data_channel_if #(.DATA_W(64)) rif ();

  read_data_channel #(
    .DATA_W     (64),
    .FIFO_DEPTH (4),
    .LEN_W      (8)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start          (start),
    .start_len      (start_len),
    .start_size     (start_size),
    .start_addr_lsb (start_addr_lsb),
    .busy           (busy),
    .mem_valid      (mem_valid),
    .mem_data       (mem_data),
    .mem_ready      (mem_ready),
`ifdef READ_PARITY_CHECK_EN
    .mem_parity     (mem_parity),
`endif
    .r              (rif.master)
  );

  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] len, input logic [2:0] size,
                             input logic [2:0] addr);
    start          = 1'b1;
    start_len      = len;
    start_size     = size;
    start_addr_lsb = addr;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [63:0] ed,
                           input logic el, input logic [1:0] er);
    int t;
    sb.push_back('{ed, el, er});
    mem_valid = 1'b1;
    mem_data  = d;
    t = 0;
    while (mem_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    check("beat_accepted", 64'(t < 100), 64'd1);
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard side: sample mid-cycle, a beat pops on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst && rif.RVALID === 1'b1 && rif.RREADY === 1'b1) begin
      pops++;
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", rif.RDATA, e.d);
        check("rlast", 64'(rif.RLAST), 64'(e.l));
        check("rresp", 64'(rif.RRESP), 64'(e.r));
      end
    end
  end

  initial begin
    int p0;
    logic [63:0] h;
    n_rst          = 1'b0;
    start          = 1'b0;
    start_len      = '0;
    start_size     = '0;
    start_addr_lsb = '0;
    mem_valid      = 1'b0;
    mem_data       = '0;
    rif.RREADY     = 1'b0;
    #12;
    check("rst_rvalid", 64'(rif.RVALID), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_rdata", rif.RDATA, 64'd0);
    check("rst_rlast", 64'(rif.RLAST), 64'd0);
    check("rst_rresp", 64'(rif.RRESP), 64'd0);
    n_rst = 1'b1;
    tick();

    // Single byte beat at lane 3.
    rif.RREADY = 1'b1;
    start_burst(8'd0, 3'd0, 3'd3);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_mem_ready", 64'(mem_ready), 64'd1);
    send_beat(64'hFFFF_FFFF_FFFF_FFAB, 64'h0000_0000_AB00_0000, 1'b1, 2'b00);
    check("t1_busy_pop_cycle", 64'(busy), 64'd1);
    tick();
    check("t1_busy_after", 64'(busy), 64'd0);

    // Halfword burst walking lanes 0,2,4,6.
    start_burst(8'd3, 3'd1, 3'd0);
    for (int i = 0; i < 4; i++)
      send_beat(64'(16'h1111 * (i + 1)),
                64'(16'h1111 * (i + 1)) << (16 * i), 1'(i == 3), 2'b00);
    drain();

    // Full-width streaming burst.
    p0 = pops;
    start_burst(8'd7, 3'd3, 3'd5);
    for (int i = 0; i < 8; i++) begin
      check("t3_mem_ready", 64'(mem_ready), 64'd1);
      send_beat(64'h0101_0101_0101_0101 * (i + 1),
                64'h0101_0101_0101_0101 * (i + 1), 1'(i == 7), 2'b00);
      check("t3_rvalid", 64'(rif.RVALID), 64'd1);
    end
    drain();
    check("t3_pops", 64'(pops - p0), 64'd8);

    // Byte burst from lane 5 with backpressure.
    p0 = pops;
    rif.RREADY = 1'b0;
    start_burst(8'd7, 3'd0, 3'd5);
    for (int i = 0; i < 4; i++)
      send_beat(64'hFFFF_FFFF_FFFF_FF00 | 64'(8'h10 + i),
                64'(8'h10 + i) << (8 * ((5 + i) % 8)), 1'b0, 2'b00);
    mem_valid = 1'b1;
    mem_data  = 64'h14;
    h = 64'h0000_1000_0000_0000;
    for (int k = 0; k < 3; k++) begin
      check("t4_mem_ready_full", 64'(mem_ready), 64'd0);
      check("t4_head_stable", rif.RDATA, h);
      tick();
    end
    rif.RREADY = 1'b1;
    for (int i = 4; i < 8; i++)
      send_beat(64'hFFFF_FFFF_FFFF_FF00 | 64'(8'h10 + i),
                64'(8'h10 + i) << (8 * ((5 + i) % 8)), 1'(i == 7), 2'b00);
    drain();
    check("t4_pops", 64'(pops - p0), 64'd8);

    // Illegal size, with a start pulse in the middle of the burst.
    start_burst(8'd1, 3'd4, 3'd0);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 2'b10);
    start_burst(8'd0, 3'd0, 3'd0);
    check("t5_still_busy", 64'(busy), 64'd1);
    send_beat(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 2'b10);
    drain();
    tick();
    check("t5_busy_after", 64'(busy), 64'd0);

    // Reset in the middle of a burst.
    rif.RREADY = 1'b0;
    start_burst(8'd3, 3'd3, 3'd0);
    send_beat(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0, 2'b00);
    send_beat(64'h2222_2222_2222_2222, 64'h2222_2222_2222_2222, 1'b0, 2'b00);
    check("t6_rvalid_before", 64'(rif.RVALID), 64'd1);
    n_rst = 1'b0;
    #1;
    check("t6_rvalid_rst", 64'(rif.RVALID), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_mem_ready_rst", 64'(mem_ready), 64'd0);
    sb.delete();
    tick();
    n_rst = 1'b1;
    tick();
    rif.RREADY = 1'b1;
    start_burst(8'd0, 3'd2, 3'd4);
    send_beat(64'hFFFF_FFFF_DEAD_BEEF, 64'hDEAD_BEEF_0000_0000, 1'b1, 2'b00);
    drain();
    tick();
    check("t6_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
